ps2_cmd_tx: RTL and testbench

Host-to-device PS/2 command transmitter: it sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the FPGA to the keyboard using the PS/2 host-request handshake. It sits beside the keyboard receive path on the shared `PS2_CLK`/`PS2_DAT` open-drain lines and supplies the `the_command` / `send_command` path of the PS/2 controller. It owns the lines only while a transmission is in progress. Otherwise it leaves both lines released.

---
 rtl/ps2_cmd_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_cmd_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_tx.sv
// ps2_cmd_tx: host-to-device PS/2 command transmitter.
// Performs the host-request handshake (clock inhibit, start bit, release),
// then shifts out 8 data bits, odd parity and stop on device falling edges,
// and waits for the device ack and idle lines.
// Optional build macro PS2_TX_ACK_CHECK_EN: when defined, a high ack bit is
// reported as an error; when undefined the ack value is ignored.
module ps2_cmd_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  logic       PS2_CLK,
    inout  logic       PS2_DAT,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic       busy
);

    localparam int MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int MAX_C = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_FIRST,
        S_SEND,
        S_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;          // inhibit / start / transfer timer
    logic [3:0]       bit_cnt_q, bit_cnt_d;  // bits presented so far
    logic [8:0]       sh_q, sh_d;            // {parity, data}, shifted LSB-first
    logic             tx_low_q, tx_low_d;    // current bit wants PS2_DAT low
    logic             sent_q, sent_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic clk_fall;
    logic clk_drive_low;
    logic dat_drive_low;

    // Two-flop synchronizers for both pads plus previous clock for edge detection.
    // Reset to 1 so leaving reset never produces a false falling edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_s2_q;

    // State, timer, shift register and output-pulse registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            tx_low_q  <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            tx_low_q  <= tx_low_d;
            sent_q    <= sent_d;
        end
    end

    // Next-state logic; timeouts are checked before edges so expiry wins a tie.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        tx_low_d  = tx_low_q;
        sent_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                tx_low_d = 1'b0;
                if (send_command) begin
                    sh_d      = {~^the_command, the_command};
                    bit_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    tx_low_d = 1'b1;   // start bit, visible during REQ
                    state_d  = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                if (cnt_q == START_LAST) begin
                    state_d = S_ERROR;
                end else if (clk_fall) begin
                    cnt_d     = '0;
                    tx_low_d  = ~sh_q[0];
                    sh_d      = {1'b1, sh_q[8:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (cnt_q == XFER_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_fall) begin
                        if (bit_cnt_q == 4'd9) begin
                            // Stop bit: line released, then wait for the ack edge.
                            tx_low_d = 1'b0;
                            state_d  = S_ACK;
                        end else begin
                            tx_low_d  = ~sh_q[0];
                            sh_d      = {1'b1, sh_q[8:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                tx_low_d = 1'b0;
                if (cnt_q == XFER_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        state_d = dat_s2_q ? S_ERROR : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                if (cnt_q == XFER_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_s2_q && dat_s2_q) begin
                        sent_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERROR: begin
                cnt_d    = '0;
                tx_low_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign clk_drive_low = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign dat_drive_low = tx_low_q &&
                           ((state_q == S_REQ) || (state_q == S_WAIT_FIRST) || (state_q == S_SEND));

    assign PS2_CLK = clk_drive_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drive_low ? 1'b0 : 1'bz;

    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = (state_q == S_ERROR);
    assign busy                          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Bench for ps2_cmd_tx: behavioural PS/2 device on pulled-up open-drain lines,
// bit scoreboard filled when a command is requested and drained at device
// rising edges. Timing parameters are scaled down to keep runs short.
module tb_ps2_cmd_tx;

    localparam int INH  = 40;
    localparam int STO  = 3000;
    localparam int XTO  = 2500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       send = 1'b0;
    logic       sent, err, busy;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_cmd_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO)
    ) dut (
        .CLOCK_50                     (clk),
        .resetn                       (resetn),
        .the_command                  (cmd),
        .send_command                 (send),
        .PS2_CLK                      (ps2_clk),
        .PS2_DAT                      (ps2_dat),
        .command_was_sent             (sent),
        .error_communication_timed_out(err),
        .busy                         (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sent_cnt = 0;
    int err_cnt  = 0;
    int err_cyc  = 0;
    always @(negedge clk) begin
        if (sent) sent_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic dev_sample(input string tag);
        logic b;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            b = exp_q.pop_front();
            check_eq(tag, 32'(ps2_dat), 32'(b));
        end
    endtask

    // Request a command, measure the inhibit window, then read the start bit.
    task automatic start_req(input logic [7:0] c, output int wf_cyc);
        int   lowc, datc, guard;
        logic last_dat;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(c[i]);
        exp_q.push_back(~^c);
        exp_q.push_back(1'b1);
        @(negedge clk);
        cmd  = c;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check_eq("clk_low_after_req", 32'(ps2_clk), 32'd0);
        lowc = 0; datc = 0; guard = 0; last_dat = 1'b1;
        while (ps2_clk === 1'b0 && guard < 4 * INH) begin
            lowc++;
            if (ps2_dat === 1'b0) datc++;
            last_dat = ps2_dat;
            guard++;
            @(negedge clk);
        end
        wf_cyc = cyc;
        check_eq("clk_low_len", lowc, INH + 1);
        check_eq("dat_low_len", datc, 1);
        check_eq("dat_low_last", 32'(last_dat), 32'd0);
        dev_sample("start_bit");
    endtask

    // One device clock pulse; the host bit is read when the clock rises.
    task automatic dev_bit(output int fall_cyc);
        @(negedge clk);
        dev_clk_low = 1'b1;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        dev_sample("data_bit");
        repeat (HALF) @(negedge clk);
    endtask

    task automatic dev_ack(input logic drive_low);
        @(negedge clk);
        dev_dat_low = drive_low;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    // Wait (bounded) for a completion pulse, then check outcome and idle lines.
    task automatic finish_xfer(input string tag, input int s0, input int e0,
                               input int exp_sent, input int exp_err, input int limit);
        int n;
        n = 0;
        while ((sent_cnt + err_cnt) == (s0 + e0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check_eq({tag, "_sent_pulses"}, sent_cnt - s0, exp_sent);
        check_eq({tag, "_err_pulses"}, err_cnt - e0, exp_err);
        check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_clk_released"}, 32'(ps2_clk), 32'd1);
        check_eq({tag, "_dat_released"}, 32'(ps2_dat), 32'd1);
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] c, input logic ack_low,
                             input int exp_sent, input int exp_err);
        int s0, e0, wf, fc;
        s0 = sent_cnt;
        e0 = err_cnt;
        start_req(c, wf);
        for (int i = 0; i < 10; i++) dev_bit(fc);
        check_eq({tag, "_all_bits_seen"}, exp_q.size(), 0);
        dev_ack(ack_low);
        finish_xfer(tag, s0, e0, exp_sent, exp_err, 4 * HALF + 50);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got no end of test, expected finish within %0d cycles", 60000);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, wf, fc, first_fc;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sent", 32'(sent), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_clk_z", 32'(ps2_clk), 32'd1);
        check_eq("rst_dat_z", 32'(ps2_dat), 32'd1);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        full_xfer("cmd_ed", 8'hED, 1'b1, 1, 0);
        full_xfer("cmd_f4", 8'hF4, 1'b1, 1, 0);

        // Device never clocks: start timeout measured from WAIT_FIRST entry.
        s0 = sent_cnt;
        e0 = err_cnt;
        start_req(8'h3C, wf);
        exp_q.delete();
        finish_xfer("no_clock", s0, e0, 0, 1, STO + 100);
        check_eq("start_timeout_len", err_cyc - wf, STO);

        // Device stops after 4 bits: transfer timeout from the first pad fall,
        // plus the 3-cycle synchronizer/edge detection latency.
        s0 = sent_cnt;
        e0 = err_cnt;
        start_req(8'hA5, wf);
        dev_bit(first_fc);
        for (int i = 0; i < 3; i++) dev_bit(fc);
        exp_q.delete();
        finish_xfer("stall", s0, e0, 0, 1, XTO + 100);
        check_eq("xfer_timeout_len", err_cyc - first_fc, XTO + 3);

        // Device leaves PS2_DAT high at the ack edge.
`ifdef PS2_TX_ACK_CHECK_EN
        full_xfer("bad_ack", 8'h5A, 1'b0, 0, 1);
`else
        full_xfer("bad_ack", 8'h5A, 1'b0, 1, 0);
`endif

        // Reset in the middle of SEND while a 0 bit is being driven.
        s0 = sent_cnt;
        e0 = err_cnt;
        start_req(8'h00, wf);
        for (int i = 0; i < 3; i++) dev_bit(fc);
        exp_q.delete();
        check_eq("mid_send_dat_driven", 32'(ps2_dat), 32'd0);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_clk_z", 32'(ps2_clk), 32'd1);
        check_eq("mid_rst_dat_z", 32'(ps2_dat), 32'd1);
        check_eq("mid_rst_sent", 32'(sent), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("mid_rst_no_sent_pulse", sent_cnt - s0, 0);
        check_eq("mid_rst_no_err_pulse", err_cnt - e0, 0);

        full_xfer("cmd_ff", 8'hFF, 1'b1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
